gth_rx_sample_deframer: RTL and testbench
=========================================

// Module: gth_rx_sample_deframer
// PURPOSE
//  Far-end receiver for the anti-probe comparator sample link. Takes 80-bit words from the
//  GTH RX user datapath (rx_usrclk2 domain) and hunts for frame alignment, driving the
//  transceiver RX slide until the sync field is found. Once locked, it de-interleaves the
//  four comparator channels (pads 0..3) and buffers them in a small FIFO behind a
//  valid/ready stream, with loss-of-lock and error accounting.
// PARAMETERS
//  SYNC_WORD   16'hA55A  value of frame bits [79:64] in every valid frame
//  LOCK_COUNT  8         consecutive good syncs needed to declare lock (>=1)
//  LOSS_COUNT  4         consecutive bad syncs while LOCKED that drop lock (>=1)
//  SLIP_WAIT   32        cycles to ignore rx_data after an rx_slip pulse (>=1)
//  FIFO_DEPTH  4         output FIFO entries (power of two, >=2)
// PORTS
//  rx_clk        in   1   GTH RX usrclk2; all logic on rising edge
//  rx_rst_n      in   1   asynchronous active-low reset, release synchronous to rx_clk
//  rx_data       in   80  GTH RX user data word
//  rx_valid      in   1   rx_data valid this cycle (RX reset done)
//  rx_slip       out  1   one-cycle RX slide request to the transceiver
//  locked        out  1   high in LOCKED state
//  m_data        out  64  m_data[16*c+i] = channel c, sample i (i=0 oldest)
//  m_valid       out  1   FIFO head valid
//  m_ready       in   1   downstream accept; transfer when m_valid & m_ready
//  drop_cnt      out  16  frames lost to FIFO full, saturating
//  sync_err_cnt  out  16  bad-sync frames seen while LOCKED, saturating
//  lock_loss_cnt out  8   LOCKED->HUNT transitions, saturating
// BEHAVIOUR
//  Frame format: [79:64] sync; [63:0] sample i of channel c at bit 4*i+c.
//  Reset: rx_slip=0, locked=0, m_valid=0, m_data=0, all counters 0, FSM=HUNT, FIFO empty.
//  rx_data/rx_valid are registered once (stage S1); all decisions use S1. A frame is
//   "good" when S1 valid and S1[79:64]==SYNC_WORD. Cycles with rx_valid=0 are ignored
//   (no state, counter or FIFO change).
//  FSM:
//   HUNT : good -> CHECK (run=1). bad -> pulse rx_slip for 1 cycle, go SLIP.
//   SLIP : count SLIP_WAIT cycles, ignore all frames, then -> HUNT.
//   CHECK: good -> run+1; run reaches LOCK_COUNT -> LOCKED. bad -> pulse rx_slip, SLIP.
//          LOCK_COUNT=1: first good frame in HUNT goes straight to LOCKED.
//   LOCKED: good -> push frame, clear miss. bad -> sync_err_cnt+1, frame not pushed,
//          miss+1; miss reaches LOSS_COUNT -> HUNT, lock_loss_cnt+1, no slip issued.
//  Only frames good in LOCKED are pushed; the frame completing lock is not pushed.
//  Push with FIFO full: frame discarded, drop_cnt+1; FIFO content is untouched.
//  Simultaneous push and pop when full: the pop frees the slot, the push is accepted.
//  Latency: good frame on rx_data at edge N -> written at N+2 -> m_valid/m_data at N+2
//   when the FIFO was empty. m_data holds while m_valid & !m_ready.
//  Loss of lock does not flush the FIFO; buffered frames still drain.
//  Counters saturate at all-ones (no wrap). rx_slip never high two cycles in a row.
//  Async reset mid-frame: everything returns to reset values at once, FIFO emptied.
// TESTING
//  1 Aligned stream, sync=A55A, rx_data[63:0]=64'h0123_4567_89AB_CDEF, m_ready=1 ->
//    locked after 8 frames; 9th frame appears de-interleaved 2 cycles later; 0 slips.
//  2 Stream rotated 3 bits; TB model rotates back by 1 per rx_slip -> exactly 3 rx_slip
//    pulses, each separated by >=33 cycles; locked follows after 8 good frames.
//  3 Locked; corrupt sync on 3 frames, then 1 good -> sync_err_cnt=3, stay locked. Then
//    4 bad in a row -> locked=0, lock_loss_cnt=1, FSM HUNT, no rx_slip on that frame.
//  4 Locked, m_ready=0 for 10 good frames, FIFO_DEPTH=4 -> 4 buffered, drop_cnt=6;
//    release m_ready -> the 4 oldest frames drain in order, unchanged.
//  5 rx_valid toggles 1/0 every cycle during CHECK -> lock still after 8 valid frames;
//    invalid cycles change nothing.
//  6 Assert rx_rst_n=0 asynchronously while locked with FIFO half full -> all outputs 0
//    before the next edge; after release, HUNT, empty FIFO, counters 0.
//  Plus: force drop_cnt to 16'hFFFE, overflow 3 more frames -> holds 16'hFFFF.

Source files
------------

// File: rtl/gth_rx_sample_deframer.sv
// gth_rx_sample_deframer: GTH RX frame aligner, channel de-interleaver and output FIFO
module gth_rx_sample_deframer #(
  parameter logic [15:0] SYNC_WORD  = 16'hA55A,
  parameter int          LOCK_COUNT = 8,
  parameter int          LOSS_COUNT = 4,
  parameter int          SLIP_WAIT  = 32,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        rx_clk,
  input  logic        rx_rst_n,
  input  logic [79:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_slip,
  output logic        locked,
  output logic [63:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] drop_cnt,
  output logic [15:0] sync_err_cnt,
  output logic [7:0]  lock_loss_cnt
);
  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(LOSS_COUNT + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [RW-1:0] LOCK_N    = RW'(LOCK_COUNT);
  localparam logic [MW-1:0] LOSS_N    = MW'(LOSS_COUNT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT - 1);
  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] SLIP   = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] LOCKED = 2'd3;
  logic [79:0]   s1_data_q;
  logic          s1_valid_q;
  logic [1:0]    state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic [MW-1:0] miss_q, miss_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          slip_q, slip_d;
  logic [15:0]   drop_q, drop_d, serr_q, serr_d;
  logic [7:0]    loss_q, loss_d;
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic [63:0]   mem_q [FIFO_DEPTH];
  logic [63:0]   deint;
  logic          sync_ok, good, bad, push_req, push, pop, full, empty;
  assign sync_ok  = s1_data_q[79:64] == SYNC_WORD;
  assign good     = s1_valid_q & sync_ok;
  assign bad      = s1_valid_q & ~sync_ok;
  assign empty    = wr_q == rd_q;
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop      = ~empty & m_ready;
  assign push_req = (state_q == LOCKED) & good;
  assign push     = push_req & (~full | pop);
  assign wr_d     = push ? wr_q + 1'b1 : wr_q;
  assign rd_d     = pop ? rd_q + 1'b1 : rd_q;
  assign drop_d   = (push_req & ~push & ~&drop_q) ? drop_q + 16'd1 : drop_q;
  assign rx_slip       = slip_q;
  assign locked        = state_q == LOCKED;
  assign m_valid       = ~empty;
  assign m_data        = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign drop_cnt      = drop_q;
  assign sync_err_cnt  = serr_q;
  assign lock_loss_cnt = loss_q;
  // alignment FSM: hunt/slip until sync repeats LOCK_COUNT times, drop lock after LOSS_COUNT misses
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    miss_d  = miss_q;
    wait_d  = wait_q;
    slip_d  = 1'b0;
    serr_d  = serr_q;
    loss_d  = loss_q;
    case (state_q)
      HUNT: begin
        if (good) begin
          run_d   = RW'(1);
          miss_d  = '0;
          state_d = (LOCK_N == RW'(1)) ? LOCKED : CHECK;
        end else if (bad) begin
          slip_d  = 1'b1;
          wait_d  = '0;
          state_d = SLIP;
        end
      end
      SLIP: begin
        wait_d  = wait_q + 1'b1;
        state_d = (wait_q == WAIT_LAST) ? HUNT : SLIP;
      end
      CHECK: begin
        if (good) begin
          run_d   = run_q + 1'b1;
          state_d = (run_d == LOCK_N) ? LOCKED : CHECK;
        end else if (bad) begin
          slip_d  = 1'b1;
          wait_d  = '0;
          state_d = SLIP;
        end
      end
      default: begin
        if (good) begin
          miss_d = '0;
        end else if (bad) begin
          serr_d = (&serr_q) ? serr_q : serr_q + 16'd1;
          miss_d = miss_q + 1'b1;
          if (miss_d == LOSS_N) begin
            state_d = HUNT;
            loss_d  = (&loss_q) ? loss_q : loss_q + 8'd1;
          end
        end
      end
    endcase
  end
  // frame bit 4*i+c is sample i of channel c; regroup into 16-bit channel lanes
  always_comb begin
    deint = '0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 16; i++)
        deint[16*c+i] = s1_data_q[4*i+c];
  end
  // FIFO storage needs no reset: the pointers define what is valid
  always_ff @(posedge rx_clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= deint;
  end
  // input stage, FSM, counters and FIFO pointers
  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
      state_q    <= HUNT;
      run_q      <= '0;
      miss_q     <= '0;
      wait_q     <= '0;
      slip_q     <= 1'b0;
      drop_q     <= '0;
      serr_q     <= '0;
      loss_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      s1_data_q  <= rx_data;
      s1_valid_q <= rx_valid;
      state_q    <= state_d;
      run_q      <= run_d;
      miss_q     <= miss_d;
      wait_q     <= wait_d;
      slip_q     <= slip_d;
      drop_q     <= drop_d;
      serr_q     <= serr_d;
      loss_q     <= loss_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end
endmodule

// File: tb/tb_gth_rx_sample_deframer.sv
// tb_gth_rx_sample_deframer: directed stimulus with a queue scoreboard on the output stream
module tb_gth_rx_sample_deframer;
  localparam logic [15:0] SYNC = 16'hA55A;
  localparam logic [63:0] P1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] E1 = 64'h00FF_0F0F_3333_5555;
  logic        rx_clk = 1'b0;
  logic        rx_rst_n = 1'b0;
  logic [79:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        m_ready = 1'b1;
  logic        rx_slip, locked, m_valid;
  logic [63:0] m_data;
  logic [15:0] drop_cnt, sync_err_cnt;
  logic [7:0]  lock_loss_cnt;
  logic [63:0] exp_q [$];
  logic [63:0] pay [10];
  logic [63:0] pexp [4];
  int checks = 0, errors = 0, slips = 0, slips0 = 0, rot = 0, cyc_n = 0;
  int last_slip = -1000, min_gap = 1000;

  gth_rx_sample_deframer dut (
    .rx_clk(rx_clk), .rx_rst_n(rx_rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_slip(rx_slip), .locked(locked), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .drop_cnt(drop_cnt), .sync_err_cnt(sync_err_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 rx_clk = ~rx_clk;
  always @(posedge rx_clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(negedge rx_clk) begin
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %h, required no output", m_data);
      end else check("m_data", m_data, exp_q.pop_front());
    end
  end

  function automatic logic [79:0] rotr(input logic [79:0] f, input int r);
    return (f >> r) | (f << (80 - r));
  endfunction

  task automatic cyc(input logic v, input logic [79:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge rx_clk);
    #1;
    if (rx_slip) begin
      slips++;
      if (cyc_n - last_slip < min_gap) min_gap = cyc_n - last_slip;
      last_slip = cyc_n;
      if (rot > 0) rot--;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0);
  endtask

  task automatic do_reset;
    rx_rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    m_ready  = 1'b1;
    rot      = 0;
    exp_q.delete();
    @(posedge rx_clk);
    @(negedge rx_clk);
    rx_rst_n = 1'b1;
    @(posedge rx_clk);
    #1;
    check("rst_slip", 64'(rx_slip), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_serr", 64'(sync_err_cnt), 64'd0);
    check("rst_loss", 64'(lock_loss_cnt), 64'd0);
  endtask

  task automatic lock_aligned(input logic [63:0] p, input logic [63:0] e);
    for (int k = 1; k <= 9; k++) begin
      cyc(1'b1, {SYNC, p});
      if (k == 8) check("lock_early", 64'(locked), 64'd0);
    end
    check("lock", 64'(locked), 64'd1);
    check("lat_n1_valid", 64'(m_valid), 64'd0);
    exp_q.push_back(e);
    cyc(1'b0, '0);
    check("lat_n2_valid", 64'(m_valid), 64'd1);
    check("lat_n2_data", m_data, e);
  endtask

  initial begin
    pay  = '{64'h0000_0000_0000_000F, 64'h1111_1111_1111_1111, 64'h8888_8888_8888_8888,
             64'hA5A5_A5A5_A5A5_A5A5, 64'h2222_2222_2222_2222, 64'h4444_4444_4444_4444,
             64'hF000_0000_0000_0000, 64'h0000_0000_0000_00F0, 64'h0000_0000_0000_0012,
             64'h0000_0000_0000_0001};
    pexp = '{64'h0001_0001_0001_0001, 64'h0000_0000_0000_FFFF,
             64'hFFFF_0000_0000_0000, 64'hAAAA_5555_AAAA_5555};
    // aligned stream: lock after 8, ninth frame out two cycles later, no slips
    do_reset();
    slips = 0;
    lock_aligned(P1, E1);
    idle(3);
    check("t1_slips", 64'(slips), 64'd0);
    // stream rotated by 3 bits, one bit recovered per slip
    do_reset();
    slips = 0;
    min_gap = 1000;
    last_slip = -1000;
    rot = 3;
    for (int i = 0; i < 400 && !locked; i++) cyc(1'b1, rotr({SYNC, P1}, rot));
    check("t2_locked", 64'(locked), 64'd1);
    check("t2_slips", 64'(slips), 64'd3);
    check("t2_gap_ge33", 64'(min_gap >= 33), 64'd1);
    if (locked) exp_q.push_back(E1);
    cyc(1'b0, '0);
    // three bad syncs keep lock, four in a row drop it without a slip
    for (int i = 0; i < 3; i++) cyc(1'b1, {16'h0000, P1});
    exp_q.push_back(pexp[1]);
    cyc(1'b1, {SYNC, pay[1]});
    cyc(1'b0, '0);
    check("t3_serr3", 64'(sync_err_cnt), 64'd3);
    check("t3_still_locked", 64'(locked), 64'd1);
    slips0 = slips;
    for (int i = 0; i < 4; i++) cyc(1'b1, {16'h0000, P1});
    idle(2);
    check("t3_unlocked", 64'(locked), 64'd0);
    check("t3_loss", 64'(lock_loss_cnt), 64'd1);
    check("t3_serr7", 64'(sync_err_cnt), 64'd7);
    check("t3_no_slip", 64'(slips), 64'(slips0));
    cyc(1'b1, {16'h0000, P1});
    cyc(1'b0, '0);
    check("t3_hunt_slips", 64'(slips), 64'(slips0 + 1));
    // backpressure: 4 buffered, 6 dropped, then saturation of the drop counter
    do_reset();
    lock_aligned(pay[4], 64'h0000_0000_FFFF_0000);
    idle(2);
    m_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k < 4) exp_q.push_back(pexp[k]);
      cyc(1'b1, {SYNC, pay[k]});
    end
    cyc(1'b0, '0);
    check("t4_drop6", 64'(drop_cnt), 64'd6);
    check("t4_valid", 64'(m_valid), 64'd1);
    idle(3);
    check("t4_hold", m_data, pexp[0]);
    force dut.drop_q = 16'hFFFE;
    cyc(1'b0, '0);
    release dut.drop_q;
    cyc(1'b0, '0);
    check("sat_fffe", 64'(drop_cnt), 64'hFFFE);
    for (int i = 0; i < 3; i++) cyc(1'b1, {SYNC, pay[0]});
    cyc(1'b0, '0);
    check("sat_ffff", 64'(drop_cnt), 64'hFFFF);
    check("sat_head", m_data, pexp[0]);
    m_ready = 1'b1;
    idle(6);
    check("t4_drained", 64'(exp_q.size()), 64'd0);
    // rx_valid toggling during acquisition: only valid frames count
    do_reset();
    slips0 = slips;
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, {SYNC, P1});
      cyc(1'b0, {16'h0000, 64'hDEAD_BEEF_DEAD_BEEF});
      check("t5_locked", 64'(locked), 64'(k == 8));
    end
    check("t5_no_push", 64'(m_valid), 64'd0);
    check("t5_no_slip", 64'(slips), 64'(slips0));
    // async reset while locked with a partly filled FIFO
    do_reset();
    lock_aligned(pay[6], 64'h8000_8000_8000_8000);
    idle(2);
    m_ready = 1'b0;
    cyc(1'b1, {16'h0000, P1});
    cyc(1'b1, {SYNC, pay[1]});
    cyc(1'b1, {SYNC, pay[2]});
    idle(2);
    check("t6_pre_valid", 64'(m_valid), 64'd1);
    check("t6_pre_serr", 64'(sync_err_cnt), 64'd1);
    #2;
    rx_rst_n = 1'b0;
    #1;
    check("t6_async_locked", 64'(locked), 64'd0);
    check("t6_async_valid", 64'(m_valid), 64'd0);
    check("t6_async_data", m_data, 64'd0);
    check("t6_async_serr", 64'(sync_err_cnt), 64'd0);
    check("t6_async_drop", 64'(drop_cnt), 64'd0);
    check("t6_async_loss", 64'(lock_loss_cnt), 64'd0);
    check("t6_async_slip", 64'(rx_slip), 64'd0);
    @(negedge rx_clk);
    rx_rst_n = 1'b1;
    m_ready = 1'b1;
    @(posedge rx_clk);
    #1;
    check("t6_post_valid", 64'(m_valid), 64'd0);
    check("t6_post_locked", 64'(locked), 64'd0);
    lock_aligned(pay[8], 64'h0000_0000_0001_0002);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) cyc(1'b0, '0);
    check("final_drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
